// File: rtl/fuzz_stim_misr_if.sv
// Bundles the fuzz block's data-path and status signals.
// The master is the sequence controller together with the DUT under fuzz.
interface fuzz_stim_misr_if #(
  parameter int IN_W  = 86,
  parameter int OUT_W = 81
);
  logic             start;
  logic [IN_W-1:0]  seed;
  logic [OUT_W-1:0] exp_sig;
  logic [OUT_W-1:0] resp;
  logic [IN_W-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] signature;
  logic [7:0]       vec_cnt;

  modport master (
    output start, seed, exp_sig, resp,
    input  stim, busy, done, pass, signature, vec_cnt
  );

  modport slave (
    input  start, seed, exp_sig, resp,
    output stim, busy, done, pass, signature, vec_cnt
  );
endinterface

// File: rtl/fuzz_stim_misr.sv
// Seeded LFSR stimulus generator with a MISR that compacts the DUT response.
// Each run applies one all-zero vector followed by NUM_VEC LFSR vectors.
module fuzz_stim_misr #(
  parameter int IN_W     = 86,
  parameter int OUT_W    = 81,
  parameter int NUM_VEC  = 21,
  parameter int TAP      = IN_W - 3,
  parameter int RESP_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  fuzz_stim_misr_if.slave bus
);

  localparam int RUN_CW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  typedef enum logic [2:0] {IDLE, ZERO, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [IN_W-1:0]    lfsr;
  logic [IN_W-1:0]    lfsr_next;
  logic [IN_W-1:0]    stim;
  logic [OUT_W-1:0]   signature;
  logic [OUT_W-1:0]   sig_next;
  logic [7:0]         vec_cnt;
  logic [RUN_CW-1:0]  run_cnt;
  logic [3:0]         drain_cnt;
  logic               busy;
  logic               done;
  logic               pass;
  logic               accept;
  logic               vld_now;
  logic               cap_vld;

  assign lfsr_next = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[TAP]};
  assign sig_next  = {signature[OUT_W-2:0], signature[OUT_W-1]} ^ bus.resp;
  assign accept    = bus.start && (state == IDLE || state == DONE);
  assign vld_now   = (state == ZERO) || (state == RUN);

  // Align the "vector applied" flag with the DUT's response latency.
  if (RESP_LAT == 0) begin : g_no_lat
    assign cap_vld = vld_now;
  end else begin : g_lat
    logic [RESP_LAT-1:0] vld_pipe;
    // NOTE: the flag pipe is control state, so it is reset; a stale 1 would cause a phantom capture.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         vld_pipe <= '0;
      else if (accept) vld_pipe <= '0;
      else             vld_pipe <= (vld_pipe << 1) | RESP_LAT'(vld_now);
    end
    assign cap_vld = vld_pipe[RESP_LAT-1];
  end

  // NOTE: every register here uses <= so all reads see pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= '0;
      stim      <= '0;
      signature <= '0;
      vec_cnt   <= '0;
      run_cnt   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      if (cap_vld) begin
        signature <= sig_next;
        if (vec_cnt != 8'hFF) vec_cnt <= vec_cnt + 8'd1;
      end
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= ZERO;
            lfsr      <= (bus.seed == '0) ? IN_W'(1) : bus.seed;
            stim      <= '0;
            signature <= '0;
            vec_cnt   <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        ZERO: begin
          state   <= RUN;
          stim    <= lfsr;
          lfsr    <= lfsr_next;
          run_cnt <= '0;
        end
        RUN: begin
          if (run_cnt == RUN_CW'(NUM_VEC - 1)) begin
            stim <= '0;
            if (RESP_LAT == 0) begin
              // The final capture lands on this same edge, so judge the post-capture signature.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == bus.exp_sig);
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            stim    <= lfsr;
            lfsr    <= lfsr_next;
            run_cnt <= run_cnt + RUN_CW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'(RESP_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == bus.exp_sig);
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim      = stim;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.signature = signature;
  assign bus.vec_cnt   = vec_cnt;

endmodule

// File: tb/tb_fuzz_stim_misr.sv
// Scoreboard bench: a small LFSR/MISR model queues expected stimulus and signatures,
// which are popped as the small-width, latency-2 and default-width instances run.
module tb_fuzz_stim_misr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fuzz_stim_misr_if #(.IN_W(8),  .OUT_W(8))  bus_a ();
  fuzz_stim_misr_if #(.IN_W(8),  .OUT_W(8))  bus_b ();
  fuzz_stim_misr_if #(.IN_W(86), .OUT_W(81)) bus_c ();

  fuzz_stim_misr #(.IN_W(8), .OUT_W(8), .NUM_VEC(3), .TAP(5), .RESP_LAT(0))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  fuzz_stim_misr #(.IN_W(8), .OUT_W(8), .NUM_VEC(3), .TAP(5), .RESP_LAT(2))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  fuzz_stim_misr u_c (.clk(clk), .rst(rst), .bus(bus_c));

  // DUT stand-ins: combinational loopback, two-stage registered loopback, truncated loopback.
  logic [7:0] r1 = '0;
  logic [7:0] r2 = '0;
  always @(posedge clk) begin
    r1 <= bus_b.stim;
    r2 <= r1;
  end
  assign bus_a.resp = bus_a.stim;
  assign bus_b.resp = r2;
  assign bus_c.resp = bus_c.stim[80:0];

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] exp_stim_q[$];
  logic [127:0] exp_sig_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [127:0] mask_w(input int w);
    return (128'd1 << w) - 128'd1;
  endfunction

  function automatic logic [127:0] lfsr_step(input logic [127:0] v, input int w, input int tap);
    logic fb;
    fb = v[w-1] ^ v[tap];
    return ((v << 1) | 128'(fb)) & mask_w(w);
  endfunction

  function automatic logic [127:0] rot(input logic [127:0] v, input int w);
    return ((v << 1) | 128'(v[w-1])) & mask_w(w);
  endfunction

  // Queue the stimulus the block must apply (zero, NUM_VEC LFSR words, zero) and the loopback signature.
  task automatic push_run(input logic [127:0] seed_v, input int in_w, input int out_w,
                          input int tap, input int nvec);
    logic [127:0] lf;
    logic [127:0] sig;
    lf  = (seed_v == '0) ? 128'd1 : seed_v;
    sig = '0;
    exp_stim_q.push_back('0);
    sig = rot(sig, out_w);
    for (int i = 0; i < nvec; i++) begin
      exp_stim_q.push_back(lf);
      sig = rot(sig, out_w) ^ (lf & mask_w(out_w));
      lf  = lfsr_step(lf, in_w, tap);
    end
    exp_stim_q.push_back('0);
    exp_sig_q.push_back(sig);
  endtask

  task automatic drive8(input bit use_b, input logic start_v, input logic [7:0] seed_v,
                        input logic [7:0] exp_v);
    if (use_b) begin
      bus_b.start = start_v; bus_b.seed = seed_v; bus_b.exp_sig = exp_v;
    end else begin
      bus_a.start = start_v; bus_a.seed = seed_v; bus_a.exp_sig = exp_v;
    end
  endtask

  task automatic run8(input bit use_b, input logic [7:0] seed_v, input logic [7:0] exp_v,
                      input bit exp_pass, input int lat);
    int busy_n;
    bit got_done;
    logic [127:0] obs;
    busy_n   = 0;
    got_done = 1'b0;
    exp_stim_q.delete();
    exp_sig_q.delete();
    @(negedge clk);
    drive8(use_b, 1'b1, seed_v, exp_v);
    push_run(128'(seed_v), 8, 8, 5, 3);
    @(negedge clk);
    drive8(use_b, 1'b0, seed_v, exp_v);
    for (int c = 0; c < 40; c++) begin
      obs = use_b ? 128'(bus_b.stim) : 128'(bus_a.stim);
      if (exp_stim_q.size() > 0) check("stim", obs, exp_stim_q.pop_front());
      if (use_b ? bus_b.busy : bus_a.busy) busy_n++;
      if (use_b ? bus_b.done : bus_a.done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_reached", 128'(got_done), 128'(1));
    check("busy_cycles", 128'(busy_n), 128'(4 + lat));
    check("stim_unconsumed", 128'(exp_stim_q.size()), 128'(0));
    obs = use_b ? 128'(bus_b.signature) : 128'(bus_a.signature);
    check("signature_model", obs, exp_sig_q.pop_front());
    check("signature_0x04", obs, 128'h04);
    obs = use_b ? 128'(bus_b.vec_cnt) : 128'(bus_a.vec_cnt);
    check("vec_cnt", obs, 128'd4);
    obs = use_b ? 128'(bus_b.pass) : 128'(bus_a.pass);
    check("pass", obs, 128'(exp_pass));
  endtask

  task automatic run_default();
    logic [85:0]  seed_v;
    logic [80:0]  sig_exp;
    logic [127:0] sig_tmp;
    int busy_n;
    bit got_done;
    busy_n   = 0;
    got_done = 1'b0;
    seed_v   = '1;
    exp_stim_q.delete();
    exp_sig_q.delete();
    push_run(128'(seed_v), 86, 81, 83, 21);
    sig_tmp = exp_sig_q.pop_front();
    sig_exp = sig_tmp[80:0];
    @(negedge clk);
    bus_c.seed = seed_v; bus_c.exp_sig = sig_exp; bus_c.start = 1'b1;
    @(negedge clk);
    bus_c.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (exp_stim_q.size() > 0) check("c_stim", 128'(bus_c.stim), exp_stim_q.pop_front());
      if (bus_c.busy) busy_n++;
      bus_c.start = (c == 5);
      if (bus_c.done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("c_done_reached", 128'(got_done), 128'(1));
    check("c_busy_cycles", 128'(busy_n), 128'd22);
    check("c_vec_cnt", 128'(bus_c.vec_cnt), 128'd22);
    check("c_signature", 128'(bus_c.signature), 128'(sig_exp));
    check("c_pass", 128'(bus_c.pass), 128'd1);
    // Restart from DONE.
    bus_c.start = 1'b1;
    @(negedge clk);
    bus_c.start = 1'b0;
    check("c_restart_sig", 128'(bus_c.signature), 128'd0);
    check("c_restart_cnt", 128'(bus_c.vec_cnt), 128'd0);
    check("c_restart_stim", 128'(bus_c.stim), 128'd0);
    check("c_restart_busy", 128'(bus_c.busy), 128'd1);
    check("c_restart_done", 128'(bus_c.done), 128'd0);
    got_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus_c.done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("c_rerun_done", 128'(got_done), 128'(1));
    check("c_rerun_signature", 128'(bus_c.signature), 128'(sig_exp));
  endtask

  initial begin
    rst = 1'b1;
    drive8(1'b0, 1'b0, 8'h00, 8'h00);
    drive8(1'b1, 1'b0, 8'h00, 8'h00);
    bus_c.start = 1'b0; bus_c.seed = '0; bus_c.exp_sig = '0;
    #1;
    check("rst_a_stim", 128'(bus_a.stim), 128'd0);
    check("rst_a_busy", 128'(bus_a.busy), 128'd0);
    check("rst_a_done", 128'(bus_a.done), 128'd0);
    check("rst_c_sig", 128'(bus_c.signature), 128'd0);
    check("rst_c_cnt", 128'(bus_c.vec_cnt), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run8(1'b0, 8'h01, 8'h04, 1'b1, 0);   // basic loopback run
    run8(1'b0, 8'h00, 8'h04, 1'b1, 0);   // zero seed maps to 1
    run8(1'b0, 8'h01, 8'h05, 1'b0, 0);   // signature mismatch
    bus_a.exp_sig = 8'h04;
    repeat (3) @(negedge clk);
    check("done_pass_hold", 128'(bus_a.pass), 128'd0);
    check("done_sig_hold", 128'(bus_a.signature), 128'h04);
    check("done_hold", 128'(bus_a.done), 128'd1);
    run8(1'b1, 8'h01, 8'h04, 1'b1, 2);   // two-cycle response latency

    // Reset during the second RUN cycle.
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'h01, 8'h04);
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h01, 8'h04);
    @(negedge clk);
    @(negedge clk);
    check("mid_run_cnt", 128'(bus_a.vec_cnt), 128'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_stim", 128'(bus_a.stim), 128'd0);
    check("mid_rst_sig", 128'(bus_a.signature), 128'd0);
    check("mid_rst_cnt", 128'(bus_a.vec_cnt), 128'd0);
    check("mid_rst_busy", 128'(bus_a.busy), 128'd0);
    check("mid_rst_done", 128'(bus_a.done), 128'd0);
    check("mid_rst_pass", 128'(bus_a.pass), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run8(1'b0, 8'h01, 8'h04, 1'b1, 0);

    run_default();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
